// File: rtl/mm_tile_sched.sv
// mm_tile_sched: tile scheduler for the register-fed matmul array.
// Walks an M x N x K tile space (k innermost, then n, then m) and issues one
// tile per accepted handshake. Each accepted tile is tagged and carried through a
// shift register that matches the array latency, so every array result comes out
// with its coords and its accumulate first/last flags.
// Ports:
//   clk, reset (sync, active low)
//   start, cfg_m/n/k          : job launch and tile counts (latched at start)
//   busy, done                : job status; done is a one-cycle pulse
//   iss_valid/ready, iss_m/n/k: tile issue handshake toward fetch/array
//   res_valid/first/last/m/n  : tags aligned with the array result
module mm_tile_sched #(
  parameter int IDX_W    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] cfg_m,
  input  logic [IDX_W-1:0] cfg_n,
  input  logic [IDX_W-1:0] cfg_k,
  output logic             busy,
  output logic             done,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [IDX_W-1:0] iss_m,
  output logic [IDX_W-1:0] iss_n,
  output logic [IDX_W-1:0] iss_k,
  output logic             res_valid,
  output logic             res_first,
  output logic             res_last,
  output logic [IDX_W-1:0] res_m,
  output logic [IDX_W-1:0] res_n
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [IDX_W-1:0] m;
    logic [IDX_W-1:0] n;
  } tag_t;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  state_t state, state_nxt;

  logic [IDX_W-1:0] m_q, n_q, k_q;
  logic [IDX_W-1:0] cfg_m_q, cfg_n_q, cfg_k_q;
  logic             zero_done;
  tag_t [PIPE_LAT-1:0] tag_pipe;
  tag_t             tag_in;

  logic cfg_ok, launch, accept, k_last, n_last, m_last, pipe_empty;

  assign cfg_ok = (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0);
  assign launch = (state == IDLE) && start && cfg_ok;
  assign accept = iss_valid && iss_ready;
  assign k_last = (k_q == cfg_k_q - ONE);
  assign n_last = (n_q == cfg_n_q - ONE);
  assign m_last = (m_q == cfg_m_q - ONE);

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT; i++)
      if (tag_pipe[i].valid) pipe_empty = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = ISSUE;
      ISSUE:   if (accept && k_last && n_last && m_last) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    iss_valid = (state == ISSUE);
    busy      = (state != IDLE);
    // DRAIN ends the cycle after the last tag leaves, which is exactly
    // the cycle after the last res_valid.
    done      = ((state == DRAIN) && pipe_empty) || zero_done;
  end

  // Empty job: done one cycle after the start, FSM never leaves IDLE.
  always_ff @(posedge clk) begin
    if (!reset) zero_done <= 1'b0;
    else        zero_done <= (state == IDLE) && start && !cfg_ok;
  end

  // Config latch and tile walk. The final accept wraps every index back
  // to 0 so no counter ever reaches cfg.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cfg_m_q <= '0;
      cfg_n_q <= '0;
      cfg_k_q <= '0;
    end else if (launch) begin
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cfg_m_q <= cfg_m;
      cfg_n_q <= cfg_n;
      cfg_k_q <= cfg_k;
    end else if (accept) begin
      if (!k_last) begin
        k_q <= k_q + ONE;
      end else begin
        k_q <= '0;
        if (!n_last) begin
          n_q <= n_q + ONE;
        end else begin
          n_q <= '0;
          m_q <= m_last ? '0 : m_q + ONE;
        end
      end
    end
  end

  assign iss_m = m_q;
  assign iss_n = n_q;
  assign iss_k = k_q;

  // Tag pipeline: free-running, no backpressure. Idle slots carry all-zero
  // tags so the result outputs read 0 whenever res_valid is low.
  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      tag_in.first = (k_q == '0);
      tag_in.last  = k_last;
      tag_in.m     = m_q;
      tag_in.n     = n_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign res_valid = tag_pipe[PIPE_LAT-1].valid;
  assign res_first = tag_pipe[PIPE_LAT-1].first;
  assign res_last  = tag_pipe[PIPE_LAT-1].last;
  assign res_m     = tag_pipe[PIPE_LAT-1].m;
  assign res_n     = tag_pipe[PIPE_LAT-1].n;

endmodule

// File: tb/tb_mm_tile_sched.sv
// Bench for mm_tile_sched. The model holds the job as a queue of tiles built by
// nested loops (m, n, k) and a queue of pending results stamped with the cycle
// they are due; every DUT output is compared against it once per cycle.
module tb_mm_tile_sched;
  localparam int IDX_W    = 4;
  localparam int PIPE_LAT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic             iss_ready = 1'b0;
  logic             busy, done, iss_valid;
  logic [IDX_W-1:0] iss_m, iss_n, iss_k;
  logic             res_valid, res_first, res_last;
  logic [IDX_W-1:0] res_m, res_n;

  mm_tile_sched #(.IDX_W(IDX_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy), .done(done),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_m(iss_m), .iss_n(iss_n), .iss_k(iss_k),
    .res_valid(res_valid), .res_first(res_first), .res_last(res_last),
    .res_m(res_m), .res_n(res_n)
  );

  always #5 clk = ~clk;

  typedef struct {int m; int n; int k; int due;} ent_t;

  ent_t tiles[$];
  ent_t pend[$];
  bit   active = 0;
  bit   zero_pend = 0;
  int   job_k = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: compare at the negedge, advance the model, then return
  // just after the next posedge so the caller can drive the following cycle.
  task automatic tick();
    bit   exp_busy, exp_iv, exp_done;
    ent_t e;
    @(negedge clk);
    exp_busy = active;
    exp_iv   = active && (tiles.size() > 0);
    exp_done = zero_pend || (active && tiles.size() == 0 && pend.size() == 0);
    chk("busy", busy, exp_busy);
    chk("iss_valid", iss_valid, exp_iv);
    chk("done", done, exp_done);
    if (exp_iv) begin
      chk("iss_m", iss_m, tiles[0].m);
      chk("iss_n", iss_n, tiles[0].n);
      chk("iss_k", iss_k, tiles[0].k);
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      chk("res_valid", res_valid, 1);
      chk("res_m", res_m, e.m);
      chk("res_n", res_n, e.n);
      chk("res_first", res_first, e.k == 0);
      chk("res_last", res_last, e.k == job_k - 1);
    end else begin
      chk("res_valid", res_valid, 0);
    end
    if (reset) begin
      if (exp_iv && iss_ready) begin
        e = tiles.pop_front();
        e.due = cyc + PIPE_LAT;
        pend.push_back(e);
        accepts++;
      end
      if (exp_done) begin
        active = 0;
        zero_pend = 0;
      end
      if (start && !exp_busy) begin
        if (cfg_m == 0 || cfg_n == 0 || cfg_k == 0) begin
          zero_pend = 1;
        end else begin
          job_k = cfg_k;
          for (int m = 0; m < cfg_m; m++)
            for (int n = 0; n < cfg_n; n++)
              for (int k = 0; k < cfg_k; k++)
                tiles.push_back('{m, n, k, 0});
          active = 1;
        end
      end
    end else begin
      tiles.delete();
      pend.delete();
      active = 0;
      zero_pend = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // rdy_pct < 0 selects the alternating 1,0,1,0 ready pattern.
  // abort_at >= 0 pulls reset low once that many tiles were accepted.
  task automatic run_job(input int m, input int n, input int k, input int rdy_pct,
                         input int abort_at, input bit restart_mid);
    bit finished = 0;
    start = 1; cfg_m = IDX_W'(m); cfg_n = IDX_W'(n); cfg_k = IDX_W'(k);
    iss_ready = ($urandom_range(1) == 1);
    accepts = 0;
    tick();
    start = 0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      if (rdy_pct < 0) iss_ready = (i % 2 == 0);
      else             iss_ready = ($urandom_range(99) < rdy_pct);
      if (restart_mid && i == 2) begin
        start = 1; cfg_m = 3; cfg_n = 3; cfg_k = 3;
      end else begin
        start = 0;
        cfg_m = IDX_W'($urandom); cfg_n = IDX_W'($urandom); cfg_k = IDX_W'($urandom);
      end
      if (abort_at >= 0 && accepts == abort_at) begin
        reset = 0;
        iss_ready = 0;
      end
      tick();
      if (!reset) begin
        reset = 1;
        chk("rst_done", done, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_mnk", {iss_m, iss_n, iss_k}, 0);
        chk("rst_res", {res_valid, res_first, res_last, res_m, res_n}, 0);
        chk("rst_busy", busy, 0);
        finished = 1;
      end else if (!active && !zero_pend) begin
        finished = 1;
      end
    end
    start = 0;
    iss_ready = 0;
    chk("job_ended", {31'd0, active}, 0);
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("reset_outs", {busy, done, iss_valid, res_valid, res_first, res_last}, 0);
    reset = 1;
    tick();
    run_job(2, 2, 2, 100, -1, 0);   // full-rate walk
    run_job(1, 1, 3, -1, -1, 0);    // alternating stalls
    run_job(3, 1, 1, 100, -1, 0);   // first=last on every result
    run_job(2, 3, 0, 100, -1, 0);   // empty job
    run_job(2, 2, 2, 100, 3, 0);    // reset after 3 accepts
    run_job(2, 2, 2, 100, -1, 0);   // clean rerun from 000
    run_job(2, 2, 2, 70, -1, 1);    // start while busy is ignored
    run_job(1, 2, 15, 60, -1, 0);   // max k count
    run_job(15, 1, 1, 80, -1, 0);   // max m count
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(30, 100), -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
